// File: rtl/row_conv_engine.sv
// Purpose : 1-D row convolution. Per job it loads NUM_CH weight rows, then streams
//           NUM_CH rows of ROW_LEN pixels (channel-major) and accumulates the window
//           dot products across channels. Each final sum is pushed into an output FIFO.
// Latency : a result is pushed on the same edge that accepts the last-channel pixel
//           closing its window. data_out is registered one edge after rd_en.
// Backpr. : ifm_ready drops only when the pending accept would push into a full FIFO.
//           A same-cycle rd_en does not lift it.
// Ports   : clk2/rst_n clock and async active-low reset. start begins a job (IDLE only).
//           wgt_valid/wgt/wgt_ready is the weight-row handshake (tap 0 in the LSBs).
//           ifm_valid/ifm/ifm_ready is the pixel handshake.
//           rd_en/data_out/out_valid/fifo_full/fifo_count form the output FIFO read side.
//           busy is high while not IDLE. done pulses for one cycle at job end.
module row_conv_engine #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int IFM_WIDTH    = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_CH       = 2,
    parameter int ROW_LEN      = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADD_WIDTH    = 3
) (
    input  logic                              clk2,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              wgt_valid,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0] wgt,
    output logic                              wgt_ready,
    input  logic                              ifm_valid,
    input  logic [IFM_WIDTH-1:0]              ifm,
    output logic                              ifm_ready,
    input  logic                              rd_en,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              out_valid,
    output logic                              fifo_full,
    output logic [ADD_WIDTH:0]                fifo_count,
    output logic                              busy,
    output logic                              done
);
    // KERNEL_SIZE must be >= 2, and FIFO_DEPTH must be 2**ADD_WIDTH because the pointers wrap naturally.
    localparam int OUT_LEN = ROW_LEN - KERNEL_SIZE + 1;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int P_W     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int O_W     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int WROW_W  = WEIGHT_WIDTH * KERNEL_SIZE;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_WGT = 2'd1,
        STREAM   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                                  state_q;
    logic [CH_W-1:0]                         ch_w_q;
    logic [CH_W-1:0]                         ch_q;
    logic [P_W-1:0]                          p_q;
    logic [NUM_CH-1:0][WROW_W-1:0]           wgt_q;
    logic [KERNEL_SIZE-2:0][IFM_WIDTH-1:0]   win_q;      // previous pixels, index 0 oldest
    logic [DATA_WIDTH-1:0]                   psum_q [OUT_LEN];
    logic [DATA_WIDTH-1:0]                   fifo_mem_q [FIFO_DEPTH];
    logic [ADD_WIDTH-1:0]                    wr_ptr_q;
    logic [ADD_WIDTH-1:0]                    rd_ptr_q;
    logic [ADD_WIDTH:0]                      count_q;
    logic [DATA_WIDTH-1:0]                   data_out_q;

    logic                                    last_ch;
    logic                                    last_p;
    logic                                    in_win;
    logic                                    full;
    logic                                    accept;
    logic                                    push;
    logic                                    pop;
    logic [O_W-1:0]                          o_idx;
    logic [KERNEL_SIZE-1:0][IFM_WIDTH-1:0]   win;
    logic [DATA_WIDTH-1:0]                   win_sum;
    logic [DATA_WIDTH-1:0]                   acc_dat;

    assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));
    assign last_p    = (p_q == P_W'(ROW_LEN - 1));
    // Only p >= KERNEL_SIZE-1 forms a window. The stale shift contents at the start of
    // each channel are never used, which clears the shift register logically.
    assign in_win    = (p_q >= P_W'(KERNEL_SIZE - 1));
    assign full      = (count_q == (ADD_WIDTH + 1)'(FIFO_DEPTH));
    assign ifm_ready = (state_q == STREAM) && !(last_ch && in_win && full);
    assign accept    = ifm_valid && ifm_ready;
    assign push      = accept && last_ch && in_win;
    assign pop       = rd_en && (count_q != '0);
    assign o_idx     = O_W'(p_q - P_W'(KERNEL_SIZE - 1));
    assign win       = {ifm, win_q};   // incoming pixel is the newest tap

    // All arithmetic is done at DATA_WIDTH. Truncating the operands first gives the same
    // modulo-2^DATA_WIDTH result as truncating the full-width sum.
    always_comb begin
        win_sum = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            win_sum = win_sum
                    + DATA_WIDTH'(wgt_q[ch_q][k*WEIGHT_WIDTH +: WEIGHT_WIDTH])
                    * DATA_WIDTH'(win[k]);
        end
    end

    // Channel 0 starts a fresh partial sum. When NUM_CH == 1 this also pushes s directly.
    assign acc_dat = (ch_q == '0) ? win_sum : psum_q[o_idx] + win_sum;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_w_q  <= '0;
            ch_q    <= '0;
            p_q     <= '0;
            wgt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD_WGT;
                        ch_w_q  <= '0;
                    end
                end
                LOAD_WGT: begin
                    if (wgt_valid) begin
                        wgt_q[ch_w_q] <= wgt;
                        if (ch_w_q == CH_W'(NUM_CH - 1)) begin
                            state_q <= STREAM;
                            ch_q    <= '0;
                            p_q     <= '0;
                        end else begin
                            ch_w_q <= ch_w_q + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (last_p) begin
                            p_q <= '0;
                            if (last_ch) begin
                                state_q <= DONE;
                            end else begin
                                ch_q <= ch_q + 1'b1;
                            end
                        end else begin
                            p_q <= p_q + 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < KERNEL_SIZE - 2; k++) begin
                win_q[k] <= win_q[k+1];
            end
            win_q[KERNEL_SIZE-2] <= ifm;
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_LEN; i++) begin
                psum_q[i] <= '0;
            end
        end else if (accept && in_win && !last_ch) begin
            psum_q[o_idx] <= acc_dat;
        end
    end

    always_ff @(posedge clk2) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= acc_dat;
        end
    end

    // A push can only occur when the FIFO is not full, so push and pop never conflict.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                data_out_q <= fifo_mem_q[rd_ptr_q];
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign wgt_ready  = (state_q == LOAD_WGT);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign data_out   = data_out_q;
    assign out_valid  = (count_q != '0);
    assign fifo_full  = full;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_row_conv_engine.sv
// Self-checking bench for row_conv_engine (FIFO_DEPTH=4 so backpressure is reachable).
// The reference keeps job-level counts and a queue of expected results. Each window sum
// is computed directly as a plain convolution over the bench's weight/pixel arrays.
module tb_row_conv_engine;
    localparam int DW = 16, WW = 8, IW = 8, K = 3, NC = 2, RL = 8, FD = 4, AW = 2;
    localparam int OL = RL - K + 1;

    logic            clk2 = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            wgt_valid = 1'b0;
    logic [WW*K-1:0] wgt = '0;
    logic            ifm_valid = 1'b0;
    logic [IW-1:0]   ifm = '0;
    logic            rd_en = 1'b0;
    logic            wgt_ready, ifm_ready, out_valid, fifo_full, busy, done;
    logic [DW-1:0]   data_out;
    logic [AW:0]     fifo_count;

    row_conv_engine #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .IFM_WIDTH(IW), .KERNEL_SIZE(K),
        .NUM_CH(NC), .ROW_LEN(RL), .FIFO_DEPTH(FD), .ADD_WIDTH(AW)
    ) dut (
        .clk2(clk2), .rst_n(rst_n), .start(start),
        .wgt_valid(wgt_valid), .wgt(wgt), .wgt_ready(wgt_ready),
        .ifm_valid(ifm_valid), .ifm(ifm), .ifm_ready(ifm_ready),
        .rd_en(rd_en), .data_out(data_out), .out_valid(out_valid),
        .fifo_full(fifo_full), .fifo_count(fifo_count),
        .busy(busy), .done(done)
    );

    always #5 clk2 = ~clk2;

    int checks = 0;
    int failures = 0;
    int W [NC][K];
    int X [NC][RL];
    int mq[$];
    int rd_log[$];
    int exp_all[$];
    int mphase = 0, wacc = 0, pacc = 0, mdata = 0, done_cnt = 0;
    bit log_pend = 0;
    bit s_ifm_rdy, s_wgt_rdy, s_ov;
    int m_ch, m_p;
    bit m_rdy, m_pop, m_acc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Window o of the job: plain convolution over all channels, wrapped to 16 bits.
    function automatic int exp_val(input int o);
        int s = 0;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < K; k++)
                s += W[c][k] * X[c][o+k];
        return s & 32'hFFFF;
    endfunction

    function automatic logic [WW*K-1:0] pack_w(input int c);
        logic [WW*K-1:0] v = '0;
        int t;
        for (int k = 0; k < K; k++) begin
            t = W[c][k];
            v[k*WW +: WW] = t[WW-1:0];
        end
        return v;
    endfunction

    // Reference model and per-cycle compare, sampled on the falling edge.
    always @(negedge clk2) begin
        if (!rst_n) begin
            mphase = 0; wacc = 0; pacc = 0; mdata = 0; log_pend = 0;
            mq.delete();
        end
        m_ch  = pacc / RL;
        m_p   = pacc % RL;
        m_rdy = (mphase == 2) && !(m_ch == NC-1 && m_p >= K-1 && mq.size() == FD);
        chk("fifo_count", fifo_count, mq.size());
        chk("out_valid", out_valid, mq.size() != 0);
        chk("fifo_full", fifo_full, mq.size() == FD);
        chk("data_out", data_out, mdata);
        chk("busy", busy, mphase != 0);
        chk("done", done, mphase == 3);
        chk("wgt_ready", wgt_ready, mphase == 1);
        chk("ifm_ready", ifm_ready, m_rdy);
        if (rst_n) begin
            if (log_pend) rd_log.push_back(int'(data_out));
            log_pend = 0;
            if (done) done_cnt++;
            m_pop = rd_en && (mq.size() != 0);
            m_acc = ifm_valid && m_rdy;
            if (m_pop) begin
                mdata = mq.pop_front();
                log_pend = 1;
            end
            if (m_acc && m_ch == NC-1 && m_p >= K-1) mq.push_back(exp_val(m_p - K + 1));
            case (mphase)
                0: if (start) begin mphase = 1; wacc = 0; end
                1: if (wgt_valid) begin
                       wacc++;
                       if (wacc == NC) begin mphase = 2; pacc = 0; end
                   end
                2: if (m_acc) begin
                       pacc++;
                       if (pacc == NC*RL) mphase = 3;
                   end
                default: mphase = 0;
            endcase
        end
    end

    task automatic cyc();
        @(negedge clk2);
        s_ifm_rdy = ifm_ready;
        s_wgt_rdy = wgt_ready;
        s_ov      = out_valid;
        @(posedge clk2);
        #1;
    endtask

    task automatic set_basic();
        for (int p = 0; p < RL; p++) begin X[0][p] = p + 1; X[1][p] = 2; end
        W[0][0] = 1; W[0][1] = 1; W[0][2] = 1;
        W[1][0] = 2; W[1][1] = 1; W[1][2] = 2;
    endtask

    task automatic set_random();
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < K; k++) W[c][k] = $urandom_range(0, 255);
            for (int p = 0; p < RL; p++) X[c][p] = $urandom_range(0, 255);
        end
    endtask

    task automatic run_job(input int rd_pct, input int vld_pct, input int abort_at,
                           input bit glitch, input bit bp_check);
        int n = 0, guard = 0, stall = 0, c = 0, g = 0;
        bit v, relief, expect_acc = 0, bp_done = 0;
        done_cnt = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        while (c < NC && guard < 200) begin
            v = ($urandom_range(0, 99) < 70);
            wgt_valid = v;
            wgt = pack_w(c);
            cyc();
            if (v && s_wgt_rdy) c++;
            guard++;
        end
        wgt_valid = 1'b0;
        chk("wgt_rows_accepted", c, NC);
        guard = 0;
        while (n < NC*RL && guard < 4000) begin
            v = ($urandom_range(0, 99) < vld_pct);
            ifm_valid = v;
            ifm = X[n / RL][n % RL][IW-1:0];
            relief = (stall >= 2);
            rd_en = relief || ($urandom_range(0, 99) < rd_pct);
            start = glitch && (n == 5);
            cyc();
            if (expect_acc) begin
                chk("bp_accept_after_rd", v && s_ifm_rdy, 1'b1);
                expect_acc = 0;
            end
            if (v && s_ifm_rdy) begin
                n++;
                stall = 0;
            end else if (v) begin
                stall = relief ? 0 : stall + 1;
                if (bp_check && !bp_done && stall == 2) begin
                    chk("bp_full", fifo_full, 1'b1);
                    chk("bp_ready_low", ifm_ready, 1'b0);
                    chk("bp_count", fifo_count, FD);
                end
                if (bp_check && !bp_done && relief) begin
                    expect_acc = 1;
                    bp_done = 1;
                end
            end
            guard++;
            if (abort_at > 0 && n == abort_at) break;
        end
        ifm_valid = 1'b0;
        rd_en = 1'b0;
        start = 1'b0;
        if (abort_at > 0) return;
        chk("pixels_accepted", n, NC*RL);
        if (bp_check) chk("bp_seen", bp_done, 1'b1);
        while (busy && g < 10) begin cyc(); g++; end
        chk("done_pulses", done_cnt, 1);
        chk("busy_dropped", busy, 1'b0);
    endtask

    task automatic drain();
        int g = 0;
        rd_en = 1'b1;
        do begin cyc(); g++; end while (s_ov && g < 40);
        rd_en = 1'b0;
        cyc();
        chk("drain_empty", fifo_count, 0);
    endtask

    task automatic push_model_exp();
        for (int o = 0; o < OL; o++) exp_all.push_back(exp_val(o));
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, rd_log.size(), exp_all.size());
        for (int i = 0; i < rd_log.size() && i < exp_all.size(); i++)
            chk($sformatf("%s[%0d]", name, i), rd_log[i], exp_all[i]);
        rd_log.delete();
        exp_all.delete();
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_data_out", data_out, 0);
        chk("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        cyc();

        // Basic job
        set_basic();
        chk("model_pin_basic", exp_val(0), 16);
        run_job(30, 80, 0, 0, 0);
        drain();
        for (int i = 0; i < OL; i++) exp_all.push_back(16 + 3*i);
        check_log("basic");

        // Tap order: the oldest pixel multiplies tap 0
        W[0][0] = 1; W[0][1] = 2; W[0][2] = 3;
        W[1][0] = 0; W[1][1] = 0; W[1][2] = 0;
        for (int p = 0; p < RL; p++) begin X[0][p] = (p == 0) ? 1 : 0; X[1][p] = 0; end
        chk("model_pin_tap", exp_val(0), 1);
        run_job(50, 90, 0, 0, 0);
        drain();
        for (int i = 0; i < OL; i++) exp_all.push_back((i == 0) ? 1 : 0);
        check_log("tap_order");

        // Wrap
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < K; k++) W[c][k] = 255;
            for (int p = 0; p < RL; p++) X[c][p] = 255;
        end
        chk("model_pin_wrap", exp_val(3), 16'hF406);
        run_job(40, 100, 0, 0, 0);
        drain();
        for (int i = 0; i < OL; i++) exp_all.push_back(16'hF406);
        check_log("wrap");

        // Backpressure with no reads except a single relieving rd_en
        set_basic();
        run_job(0, 100, 0, 0, 1);
        drain();
        for (int i = 0; i < OL; i++) exp_all.push_back(16 + 3*i);
        check_log("backpressure");

        // Empty read: data_out holds the last value read (31)
        rd_en = 1'b1;
        cyc();
        cyc();
        rd_en = 1'b0;
        cyc();
        chk("empty_rd_hold", data_out, 31);
        chk("empty_rd_count", fifo_count, 0);
        rd_log.delete();

        // start glitch mid-STREAM, then a second job started right after DONE with unread results
        set_random();
        run_job(0, 100, 0, 1, 0);
        push_model_exp();
        set_random();
        run_job(20, 90, 0, 0, 0);
        push_model_exp();
        drain();
        check_log("restart_order");

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            set_random();
            run_job($urandom_range(0, 60), $urandom_range(40, 100), 0, 0, 0);
            push_model_exp();
            drain();
            check_log($sformatf("random%0d", j));
        end

        // Reset mid-STREAM with results still in the FIFO
        set_basic();
        run_job(0, 100, 0, 0, 0);
        run_job(0, 100, 10, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_out_valid", out_valid, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        rd_log.delete();
        exp_all.delete();
        run_job(30, 80, 0, 0, 0);
        drain();
        for (int i = 0; i < OL; i++) exp_all.push_back(16 + 3*i);
        check_log("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
